aes128_key_expand: RTL
======================

Name: aes128_key_expand

Overview:
- Upstream neighbour of the aes128 round datapath.
- Accepts a 128-bit cipher key and iteratively generates the 11 AES-128 round keys (rk0..rk10), one per cycle, into an internal key store.
- The datapath reads any round key by index, in forward order for encryption or reverse order (rk10..rk0) for decryption.
- keys_valid_o gates the core's load_i: the core must not load while expansion is in progress.

Parameters:
- RD_REG, 0, 0 = rk_o is a combinational read of the store; 1 = rk_o is registered, giving 1-cycle read latency.
- NK_WORDS, 4, key length in 32-bit words; fixed at 4 (AES-128), declared for package consistency only.

Ports:
- clk  input  1  single clock, all logic on rising edge
- rst  input  1  synchronous reset, active-high
- key_i  input  128  cipher key; key_i[127:96] is word w0
- key_valid_i  input  1  key offered this cycle
- key_ready_o  output  1  block can accept a key
- keys_valid_o  output  1  all 11 round keys are stored and stable
- busy_o  output  1  expansion in progress
- rd_idx_i  input  4  round-key index, 0..10
- rk_o  output  128  round key rd_idx_i

Behaviour:
- Reset is synchronous and active-high. It is sampled on the rising edge of clk and overrides all other inputs.
- Reset values:
  - state=IDLE, key_ready_o=1, keys_valid_o=0, busy_o=0.
  - Round counter=0, rcon=8'h01.
  - rk_o=0; key store contents are don't-care.
- FSM states: IDLE, EXPAND, DONE.
  - key_ready_o = (state != EXPAND).
  - busy_o = (state == EXPAND).
  - keys_valid_o = (state == DONE).
- Accept: key_valid_i && key_ready_o, in IDLE or DONE.
  - Next edge: store[0] <= key_i, cnt <= 1, rcon <= 8'h01, state <= EXPAND.
  - keys_valid_o deasserts on that edge when accepting from DONE.
- EXPAND, each cycle, from prev = store[cnt-1] split into words w0..w3:
  - t = SubWord(RotWord(w3)) ^ {rcon, 24'h0}
  - n0 = w0^t, n1 = w1^n0, n2 = w2^n1, n3 = w3^n2
  - store[cnt] <= {n0,n1,n2,n3}; cnt <= cnt+1
  - rcon <= xtime(rcon): shift left by 1, XOR 8'h1b if the msb was set. The sequence is 01,02,04,08,10,20,40,80,1b,36.
  - When cnt==10, write store[10] and state <= DONE.
- Latency: key accepted at edge E0 → keys_valid_o high after edge E0+10. Exactly 11 edges from the accepting edge through the final write inclusive.
- key_valid_i during EXPAND is ignored (not queued), because key_ready_o is low.
- DONE holds indefinitely. Store contents are stable until the next accept.
- Read path:
  - RD_REG=0: rk_o = store[rd_idx_i], combinational.
  - RD_REG=1: rk_o registered, reflecting rd_idx_i from the previous cycle.
  - rd_idx_i > 10 yields rk_o = 0.
  - Reading during EXPAND is legal but the returned value is undefined for unwritten indices.
- Reset mid-expansion: returns to IDLE next edge with keys_valid_o=0. Partial keys are never flagged valid.
- Simultaneous rst and key_valid_i: rst wins; the key is not accepted.
- SubWord uses four parallel S-box instances (combinational, no added latency).

Decomposition:
- Package aes128_pkg holds:
  - typedefs: word_t (32b), block_t (128b), rk_idx_t (4b)
  - constants: AES128_NR=10, AES128_NUM_RK=11, RCON_INIT=8'h01, XTIME_POLY=8'h1b
  - an xtime function
  - the FSM state enum
- Sub-module aes128_sbox: 8-bit in, 8-bit out, forward S-box lookup, purely combinational. It is instantiated four times here and reused by the round datapath.

Test Plan:
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c:
  - keys_valid_o rises exactly 10 cycles after the accepting edge.
  - rd_idx 0 → 2b7e151628aed2a6abf7158809cf4f3c.
  - rd_idx 1 → a0fafe1788542cb123a339392a6c7605.
  - rd_idx 10 → d014f9a8c9ee2589e13f0cc8b6630ca6.
- All-zero key: rk1=62636363626363636263636362636363, rk10=b4ef5bcb3e92e21123e951cf6f8f188e.
- key_valid_i held high with a different key throughout EXPAND → key_ready_o=0 for 10 cycles, the second key is ignored, and rk10 matches the first key's expansion.
- New key accepted in DONE → keys_valid_o drops on the next edge, re-rises 10 cycles later, and the store holds the second key's schedule.
- rst asserted at cnt=5 → IDLE next edge, keys_valid_o=0, key_ready_o=1; re-expansion of the FIPS key completes correctly.
- rd_idx_i=11..15 → rk_o=0. With RD_REG=1, rk_o tracks rd_idx_i with exactly 1 cycle delay.

Source files
------------

// File: rtl/aes128_pkg.sv
// Shared types, constants and helpers for the AES-128 blocks.
// Used by the key expander and the round datapath.
package aes128_pkg;

  typedef logic [31:0]  word_t;
  typedef logic [127:0] block_t;
  typedef logic [3:0]   rk_idx_t;

  localparam int          AES128_NR     = 10;
  localparam int          AES128_NUM_RK = 11;
  localparam logic [7:0]  RCON_INIT     = 8'h01;
  localparam logic [7:0]  XTIME_POLY    = 8'h1b;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXPAND,
    ST_DONE
  } ke_state_t;

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? XTIME_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/aes128_sbox.sv
// Forward AES S-box, purely combinational lookup.
// Ports:
//   in_byte  - byte to substitute
//   out_byte - S-box output
module aes128_sbox (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign out_byte = SBOX[in_byte];

endmodule

// File: rtl/aes128_key_expand.sv
// AES-128 key expander: accepts a cipher key and generates round keys
// rk0..rk10, one per cycle, into an internal store that the round
// datapath reads by index in either order.
// Ports:
//   clk, rst     - clock; synchronous active-high reset
//   key_i        - cipher key, key_i[127:96] is word w0
//   key_valid_i  - key offered this cycle
//   key_ready_o  - a key can be accepted (not expanding)
//   keys_valid_o - all 11 round keys stored and stable
//   busy_o       - expansion in progress
//   rd_idx_i     - round-key index to read (11..15 read as zero)
//   rk_o         - round key at rd_idx_i (registered when RD_REG=1)
module aes128_key_expand
  import aes128_pkg::*;
#(
  parameter bit RD_REG   = 1'b0,
  parameter int NK_WORDS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NK_WORDS*32-1:0]  key_i,
  input  logic                    key_valid_i,
  output logic                    key_ready_o,
  output logic                    keys_valid_o,
  output logic                    busy_o,
  input  rk_idx_t                 rd_idx_i,
  output block_t                  rk_o
);

  ke_state_t state, state_nxt;
  rk_idx_t   cnt;
  logic [7:0] rcon;
  block_t    prev_key;     // most recently written round key, store[cnt-1]
  block_t    next_key;
  block_t    rd_val;
  word_t     rot_word, sub_word, t_word;
  word_t     n0, n1, n2, n3;
  logic      accept;
  block_t    store [AES128_NUM_RK];

  assign key_ready_o  = (state != ST_EXPAND);
  assign busy_o       = (state == ST_EXPAND);
  assign keys_valid_o = (state == ST_DONE);
  assign accept       = key_valid_i && key_ready_o;

  // ---------------- FSM ----------------
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // NOTE: state_nxt gets its default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE, ST_DONE: if (accept) state_nxt = ST_EXPAND;
      ST_EXPAND:        if (cnt == rk_idx_t'(AES128_NR)) state_nxt = ST_DONE;
      default:          state_nxt = ST_IDLE;
    endcase
  end

  // ---------------- round-key step ----------------
  assign rot_word = {prev_key[23:0], prev_key[31:24]};

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    aes128_sbox u_sbox (
      .in_byte  (rot_word[8*g +: 8]),
      .out_byte (sub_word[8*g +: 8])
    );
  end

  assign t_word   = sub_word ^ {rcon, 24'h0};
  assign n0       = prev_key[127:96] ^ t_word;
  assign n1       = prev_key[95:64]  ^ n0;
  assign n2       = prev_key[63:32]  ^ n1;
  assign n3       = prev_key[31:0]   ^ n2;
  assign next_key = {n0, n1, n2, n3};

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      rcon     <= RCON_INIT;
      prev_key <= '0;
    end else if (accept) begin
      cnt      <= rk_idx_t'(1);
      rcon     <= RCON_INIT;
      prev_key <= key_i;
    end else if (state == ST_EXPAND) begin
      cnt      <= cnt + rk_idx_t'(1);
      rcon     <= xtime(rcon);
      prev_key <= next_key;
    end
  end

  // NOTE: the key store has no reset; its contents are meaningless until
  // keys_valid_o, so resetting 1408 flops would buy nothing.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (accept)                  store[0]   <= key_i;
      else if (state == ST_EXPAND) store[cnt] <= next_key;
    end
  end

  // ---------------- read path ----------------
  always_comb begin
    rd_val = '0;
    for (int i = 0; i < AES128_NUM_RK; i++) begin
      if (rd_idx_i == rk_idx_t'(i)) rd_val = store[i];
    end
  end

  if (RD_REG) begin : g_rd_reg
    block_t rk_q;
    always_ff @(posedge clk) begin
      if (rst) rk_q <= '0;
      else     rk_q <= rd_val;
    end
    assign rk_o = rk_q;
  end else begin : g_rd_comb
    assign rk_o = rd_val;
  end

endmodule
